fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage for the 16-bit SIMPLE-style core. It owns the program counter, issues one word-addressed request at a time to instruction memory, and latches the returned word into an instruction register. It slices the register into the `op1`/`op2`/`cond`/`op3` and operand fields consumed by the main decoder, and presents them under a valid/ready handshake. It also handles branch/jump redirects from the execute stage and, optionally, halt.

## Interface
- `PC_W`, 16, program-counter and instruction-memory address width (word addressed).
- `RESET_PC`, 0, PC value loaded on reset.
- `clk` in 1 system clock; every register is clocked on its rising edge.
- `rst_n` in 1 reset; asynchronous, active-low.
- `imem_req` out 1 single-cycle request strobe; always accepted by memory.
- `imem_addr` out PC_W request address; valid when `imem_req`=1.
- `imem_rdata` in 16 returned instruction word.
- `imem_valid` in 1 response strobe; exactly one per request, at least 1 cycle after the request.
- `redirect` in 1 taken branch/jump from execute.
- `redirect_pc` in PC_W target address.
- `insn_ready` in 1 downstream accepts the held instruction.
- `insn_valid` out 1 held instruction is valid.
- `insn` out 16 raw instruction register (IR).
- `op1` out 2 IR[15:14].
- `op2` out 3 IR[13:11].
- `cond` out 3 IR[10:8].
- `op3` out 4 IR[7:4].
- `rs` out 3 IR[13:11].
- `rd` out 3 IR[10:8].
- `d8` out 8 IR[7:0].
- `d4` out 4 IR[3:0].
- `insn_pc` out PC_W address the held instruction was fetched from.
- `halted` out 1 fetch stopped by HLT (`SIMPLE_HLT_EN` only; tied 0 otherwise).

## Operation
- States:
  - IDLE: no request outstanding, IR empty or held.
  - WAIT: one request outstanding.
  - HALTED: fetch stopped.
- At most one request is outstanding. The IR holds at most one instruction.
- Issue condition, evaluated in IDLE: `imem_req`=1 with `imem_addr`=pc when the IR is empty or is accepted this cycle (`insn_valid & insn_ready`), and `redirect`=0. On issue: go to WAIT, pc <= pc+1 (mod 2^PC_W, wraps FFFF->0000).
- WAIT with `imem_valid`=1 and no discard pending:
  - IR <= `imem_rdata`, `insn_pc` <= request address.
  - `insn_valid` <= 1.
  - Go to IDLE.
- WAIT with `imem_valid`=1 and discard pending: the response is dropped, discard is cleared, and the state goes to IDLE.
- `insn_valid` stays high, with IR and field outputs stable, until `insn_ready` is sampled high.
- Redirect has the highest priority. On `redirect`=1:
  - pc <= `redirect_pc`.
  - `insn_valid` <= 0; the IR contents are a don't-care.
  - No request is issued that cycle.
  - If in WAIT and `imem_valid`=0 the same cycle, set discard.
  - If `imem_valid`=1 the same cycle, that response is dropped and no discard is set.
- Fields are pure wires off the IR. `op2`/`rs` alias and `cond`/`rd` alias by design; the decoder picks by `op1`.

## Timing
- Reset values:
  - pc=`RESET_PC`.
  - State IDLE.
  - `imem_req`=0, `imem_addr`=0.
  - IR=0, `insn_valid`=0, `insn_pc`=0.
  - Discard=0, `halted`=0.
- First request occurs in the first clock edge after `rst_n` rises, with `imem_addr`=`RESET_PC`.
- Latency is imem latency + 1 cycle from `imem_req` to `insn_valid`.
- Throughput with 1-cycle memory and `insn_ready`=1 is one instruction per 2 cycles (no prefetch).
- Redirect in cycle N gives `insn_valid`=0 at N+1. The first target request goes out at N+1, or on the cycle after the discarded response.
- `rst_n` low mid-operation clears everything asynchronously. A response arriving during reset is ignored, and no discard is carried over.
- If `redirect` and `insn_ready` arrive together, redirect wins.

## Configuration
- `SIMPLE_HLT_EN` defined:
  - When an instruction with op1=11 and op3=1111 is accepted, the state goes to HALTED and `halted` goes to 1 next cycle.
  - No further `imem_req` is issued; redirect is ignored.
  - Only reset exits HALTED.
  - An HLT squashed by redirect before acceptance does not halt.
- `SIMPLE_HLT_EN` undefined: HLT is treated like any instruction, HALTED is unreachable, and `halted`=0.

## Test plan
- Reset release with 1-cycle memory (addr n returns 16'h1000+n) and `insn_ready`=1:
  - Requests go to addr 0,1,2 on alternate cycles.
  - `insn`=1000,1001,1002 with `insn_pc`=0,1,2.
- Backpressure: hold `insn_ready`=0 for 5 cycles after `insn_valid`.
  - IR is stable and no new `imem_req` is issued.
  - On release, the next request goes out the same cycle.
- Redirect during WAIT with 3-cycle memory: `redirect_pc`=0x40.
  - The in-flight response is discarded and `insn_valid` stays 0.
  - The next request is to 0x40 and `insn_pc`=0x40.
- Redirect coinciding with `imem_valid`: the response is dropped, the next request goes to the target the following cycle, and no later response is discarded.
- Field slicing with IR=16'hD6F3:
  - `op1`=3, `op2`/`rs`=2, `cond`/`rd`=6, `op3`=F, `d8`=F3, `d4`=3.
- With `SIMPLE_HLT_EN`, fetch of 16'hC0F0 at addr 5:
  - After acceptance, `halted`=1 and no further requests occur.
  - A redirect to 0 is ignored.
  - Pulsing `rst_n` restarts fetch at 0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the 16-bit SIMPLE-style core.
// Owns the PC, keeps at most one word-addressed request outstanding, latches
// the returned word into the IR and presents decoder fields under valid/ready.
// Taken branches/jumps from execute redirect the PC and squash the held or
// in-flight instruction.
// Optional feature macro: SIMPLE_HLT_EN. When defined, accepting an HLT
// (op1=11, op3=1111) stops fetch until reset.
module fetch_stage #(
    parameter int PC_W     = 16,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_valid,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            insn_ready,
    output logic            insn_valid,
    output logic [15:0]     insn,
    output logic [1:0]      op1,
    output logic [2:0]      op2,
    output logic [2:0]      cond,
    output logic [3:0]      op3,
    output logic [2:0]      rs,
    output logic [2:0]      rd,
    output logic [7:0]      d8,
    output logic [3:0]      d4,
    output logic [PC_W-1:0] insn_pc,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] insn_pc_q, insn_pc_d;
    logic [PC_W-1:0] req_addr_q, req_addr_d;
    logic            discard_q, discard_d;

    logic accept;
    logic is_hlt;
    logic redir;
    logic halt_now;
    logic issue;

`ifdef SIMPLE_HLT_EN
    assign is_hlt = (ir_q[15:14] == 2'b11) && (ir_q[7:4] == 4'hF);
`else
    assign is_hlt = 1'b0;
`endif

    assign accept   = valid_q & insn_ready;
    // Once halted, redirects from execute no longer steer fetch.
    assign redir    = redirect & (state_q != S_HALTED);
    // A squashing redirect in the same cycle wins over an HLT acceptance.
    assign halt_now = accept & is_hlt & ~redir;
    assign issue    = (state_q == S_IDLE) & (~valid_q | accept) & ~redir & ~halt_now;

    // Request is combinational off the IDLE state so a refill can go out in
    // the very cycle the held instruction is consumed; masked while in reset.
    assign imem_req  = issue & rst_n;
    assign imem_addr = imem_req ? pc_q : '0;

    // Next-state, PC, IR and discard bookkeeping; redirect has top priority.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        valid_d    = valid_q & ~accept;
        insn_pc_d  = insn_pc_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        case (state_q)
            S_IDLE: begin
                if (redir) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end else if (halt_now) begin
                    state_d = S_HALTED;
                end else if (issue) begin
                    state_d    = S_WAIT;
                    pc_d       = pc_q + PC_ONE;
                    req_addr_d = pc_q;
                end
            end
            S_WAIT: begin
                if (redir) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    if (imem_valid) begin
                        // Response lands with the redirect: drop it here.
                        state_d   = S_IDLE;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_valid) begin
                    state_d   = S_IDLE;
                    discard_d = 1'b0;
                    if (!discard_q) begin
                        ir_d      = imem_rdata;
                        insn_pc_d = req_addr_q;
                        valid_d   = 1'b1;
                    end
                end
            end
            S_HALTED: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_RST;
            ir_q       <= '0;
            valid_q    <= 1'b0;
            insn_pc_q  <= '0;
            req_addr_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            valid_q    <= valid_d;
            insn_pc_q  <= insn_pc_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
        end
    end

    // Decoder fields are plain slices; op2/rs and cond/rd overlap on purpose.
    assign insn       = ir_q;
    assign insn_valid = valid_q;
    assign insn_pc    = insn_pc_q;
    assign op1        = ir_q[15:14];
    assign op2        = ir_q[13:11];
    assign cond       = ir_q[10:8];
    assign op3        = ir_q[7:4];
    assign rs         = ir_q[13:11];
    assign rd         = ir_q[10:8];
    assign d8         = ir_q[7:0];
    assign d4         = ir_q[3:0];

`ifdef SIMPLE_HLT_EN
    assign halted = (state_q == S_HALTED);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed cycle tables for requests and valid,
// plus a scoreboard of expected (insn, insn_pc) popped by a monitor on every
// accepted instruction. Memory model returns 16'h1000+addr except at 5
// (16'hC0F0) and 0x20 (16'hD6F3), with a selectable latency.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        insn_ready;
    logic        insn_valid;
    logic [15:0] insn;
    logic [1:0]  op1;
    logic [2:0]  op2, cond, rs, rd;
    logic [3:0]  op3, d4;
    logic [7:0]  d8;
    logic [15:0] insn_pc;
    logic        halted;

    fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .insn_ready (insn_ready),
        .insn_valid (insn_valid),
        .insn       (insn),
        .op1        (op1),
        .op2        (op2),
        .cond       (cond),
        .op3        (op3),
        .rs         (rs),
        .rd         (rd),
        .d8         (d8),
        .d4         (d4),
        .insn_pc    (insn_pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] insn;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] i, input logic [15:0] p);
        exp_t e;
        e.insn = i;
        e.pc   = p;
        sb.push_back(e);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0005) return 16'hC0F0;
        if (a == 16'h0020) return 16'hD6F3;
        return 16'h1000 + a;
    endfunction

    // Memory model: sample request at negedge, answer exactly lat cycles later.
    int          lat = 1;
    int          pend_cnt = 0;
    logic [15:0] pend_addr = '0;

    always @(negedge clk) begin
        if (rst_n && imem_req) begin
            pend_cnt  = lat;
            pend_addr = imem_addr;
        end
    end

    always @(posedge clk) begin
        #1;
        imem_valid = 1'b0;
        if (!rst_n) begin
            pend_cnt = 0;
        end else if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(pend_addr);
            end
        end
    end

    // Monitor: every accepted instruction must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && insn_valid && insn_ready && !redirect) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected cyc=%0d got insn=%h pc=%h expected none", cyc, insn, insn_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_insn", {16'h0, insn}, {16'h0, e.insn});
                chk("sb_pc", {16'h0, insn_pc}, {16'h0, e.pc});
                $display("accept insn=%h pc=%h cyc=%0d", insn, insn_pc, cyc);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_cycle(input int exp_addr, input logic exp_valid);
        chk("req", {31'h0, imem_req}, {31'h0, (exp_addr >= 0)});
        if (exp_addr >= 0) chk("addr", {16'h0, imem_addr}, exp_addr);
        chk("valid", {31'h0, insn_valid}, {31'h0, exp_valid});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d got running expected finished", cyc);
        $fatal(1, "timeout");
    end

    int   p1_req[34];
    logic p1_val[34];
    int   p2_req[18];
    logic p2_val[18];
    logic hlt_build;

    initial begin
`ifdef SIMPLE_HLT_EN
        hlt_build = 1'b1;
`else
        hlt_build = 1'b0;
`endif
        for (int i = 0; i < 34; i++) begin
            p1_req[i] = -1;
            p1_val[i] = 1'b0;
        end
        p1_req[0] = 0;     p1_req[2] = 1;      p1_req[4] = 2;      p1_req[6] = 3;
        p1_req[13] = 4;    p1_req[16] = 'h30;  p1_req[20] = 'h40;  p1_req[24] = 'h41;
        p1_req[28] = 'h20; p1_req[30] = 'h21;
        p1_val[2] = 1'b1;  p1_val[4] = 1'b1;   p1_val[6] = 1'b1;
        for (int i = 8; i <= 13; i++) p1_val[i] = 1'b1;
        p1_val[15] = 1'b1; p1_val[24] = 1'b1;  p1_val[30] = 1'b1;
        p1_val[32] = 1'b1; p1_val[33] = 1'b1;

        for (int i = 0; i < 18; i++) begin
            p2_req[i] = -1;
            p2_val[i] = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            p2_req[2*i]     = i;
            p2_val[2*i + 2] = 1'b1;
        end
        if (!hlt_build) begin
            p2_req[12] = 6;
            for (int i = 14; i < 18; i++) p2_val[i] = 1'b1;
        end

        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        insn_ready  = 1'b1;
        imem_valid  = 1'b0;
        imem_rdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'h0, imem_req}, 0);
        chk("rst_addr", {16'h0, imem_addr}, 0);
        chk("rst_valid", {31'h0, insn_valid}, 0);
        chk("rst_insn", {16'h0, insn}, 0);
        chk("rst_insn_pc", {16'h0, insn_pc}, 0);
        chk("rst_halted", {31'h0, halted}, 0);

        // Phase 1: sequential fetch, backpressure, redirects, field slicing.
        push(16'h1000, 16'h0000);
        push(16'h1001, 16'h0001);
        push(16'h1002, 16'h0002);
        push(16'h1003, 16'h0003);
        push(16'h1040, 16'h0040);
        push(16'hD6F3, 16'h0020);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 0; k < 34; k++) begin
            case (k)
                8:  insn_ready = 1'b0;
                13: insn_ready = 1'b1;
                15: begin redirect = 1'b1; redirect_pc = 16'h0030; lat = 3; end
                16: redirect = 1'b0;
                17: begin redirect = 1'b1; redirect_pc = 16'h0040; end
                18: redirect = 1'b0;
                27: begin redirect = 1'b1; redirect_pc = 16'h0020; lat = 1; end
                28: redirect = 1'b0;
                32: insn_ready = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            chk_cycle(p1_req[k], p1_val[k]);
            if (k >= 8 && k <= 12) begin
                chk("bp_insn", {16'h0, insn}, 32'h1003);
                chk("bp_pc", {16'h0, insn_pc}, 3);
            end
            if (k == 30) begin
                chk("op1", {30'h0, op1}, 3);
                chk("op2", {29'h0, op2}, 2);
                chk("rs", {29'h0, rs}, 2);
                chk("cond", {29'h0, cond}, 6);
                chk("rd", {29'h0, rd}, 6);
                chk("op3", {28'h0, op3}, 32'hF);
                chk("d8", {24'h0, d8}, 32'hF3);
                chk("d4", {28'h0, d4}, 3);
            end
            if (k == 33) chk("held_insn", {16'h0, insn}, 32'h1021);
            next_cycle();
        end

        // Asynchronous reset mid-operation clears the held instruction at once.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'h0, insn_valid}, 0);
        chk("async_insn", {16'h0, insn}, 0);
        insn_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Phase 2: restart from 0 and run into the HLT word at address 5.
        push(16'h1000, 16'h0000);
        push(16'h1001, 16'h0001);
        push(16'h1002, 16'h0002);
        push(16'h1003, 16'h0003);
        push(16'h1004, 16'h0004);
        push(16'hC0F0, 16'h0005);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 0; k < 18; k++) begin
            if (k == 14) begin
                if (hlt_build) begin
                    redirect    = 1'b1;
                    redirect_pc = 16'h0000;
                end else begin
                    insn_ready = 1'b0;
                end
            end
            if (k == 15) redirect = 1'b0;
            @(negedge clk);
            chk_cycle(p2_req[k], p2_val[k]);
            if (k >= 13) chk("halted", {31'h0, halted}, {31'h0, hlt_build});
            next_cycle();
        end

        // Reset pulse restarts fetch at 0 and clears halted.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        insn_ready = 1'b1;
        cyc        = 0;
        @(negedge clk);
        chk("restart_req", {31'h0, imem_req}, 1);
        chk("restart_addr", {16'h0, imem_addr}, 0);
        chk("restart_halted", {31'h0, halted}, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
